// File: rtl/seg7_scan.sv
// Four-digit multiplexed hex display driver with frame snapshot and anti-ghost blanking.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_CYC);
  localparam logic             INV      = (ACTIVE_LOW != 0);

  typedef enum logic {BLANK, SHOW} slot_t;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      snap;
  logic [3:0]       dp_snap;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  logic        frame_start_p0;
  logic [15:0] nibs_p0;
  logic [3:0]  dps_p0;
  logic [3:0]  nib_p0;
  slot_t       slot_p0;
  logic        vis_p0;
  logic        on_p0;
  logic [3:0]  an_p0;
  logic [6:0]  seg_p0;
  logic        dp_p0;

  // Stage p0: decode current (idx, cnt) into active-high display drive
  always_comb begin
    frame_start_p0 = en && (idx == 2'd0) && (cnt == '0);
    // A frame-start slot must already see the incoming word if it is not blanked.
    nibs_p0 = frame_start_p0 ? data  : snap;
    dps_p0  = frame_start_p0 ? dp_in : dp_snap;
    nib_p0  = nibs_p0[{idx, 2'b00} +: 4];
    slot_p0 = (cnt < BLANK_C) ? BLANK : SHOW;
`ifdef SEG7_LZB_EN
    vis_p0 = 1'b1;
    for (int j = 1; j < 4; j++) begin
      if (idx == 2'(j))
        vis_p0 = 1'b0;
    end
    for (int j = 1; j < 4; j++) begin
      if ((2'(j) >= idx) && ((nibs_p0[4*j +: 4] != 4'h0) || dps_p0[j]))
        vis_p0 = 1'b1;
    end
`else
    vis_p0 = 1'b1;
`endif
    on_p0  = (slot_p0 == SHOW) && vis_p0;
    an_p0  = on_p0 ? (4'b0001 << idx) : 4'b0000;
    seg_p0 = on_p0 ? hex7(nib_p0) : 7'h00;
    dp_p0  = on_p0 && dps_p0[idx];
  end

  // Stage p1: registered outputs and scan state
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt     <= '0;
      idx     <= 2'd0;
      snap    <= 16'h0000;
      dp_snap <= 4'h0;
      an      <= {4{INV}};
      seg     <= {7{INV}};
      dp      <= INV;
      frame   <= 1'b0;
    end else if (!en) begin
      an      <= {4{INV}};
      seg     <= {7{INV}};
      dp      <= INV;
      frame   <= 1'b0;
    end else begin
      an      <= an_p0  ^ {4{INV}};
      seg     <= seg_p0 ^ {7{INV}};
      dp      <= dp_p0  ^ INV;
      frame   <= frame_start_p0;
      if (frame_start_p0) begin
        snap    <= data;
        dp_snap <= dp_in;
      end
      if (cnt == DIV_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: constant vector table, directed corner sequences, and a
// randomized run against a position-based reference model.
module tb_seg7_scan;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        en = 1'b0;
  logic [15:0] data = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  int n_chk = 0;
  int n_fail = 0;

  seg7_scan #(.REFRESH_DIV(DIV), .BLANK_CYC(BLANK), .ACTIVE_LOW(1)) dut (
    .clk(clk), .clr(clr), .en(en), .data(data), .dp_in(dp_in),
    .an(an), .seg(seg), .dp(dp), .frame(frame)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: position within the 32-cycle frame counts enabled cycles.
  int          pos = 0;
  logic [15:0] msnap = 16'h0;
  logic [3:0]  mdp = 4'h0;

  function automatic logic visible(input int k, input logic [15:0] s, input logic [3:0] d);
`ifdef SEG7_LZB_EN
    int lead = 0;
    for (int j = 0; j < 4; j++)
      if (s[4*j +: 4] != 4'h0 || d[j]) lead = j;
    return k <= lead;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fr;
    int k, c;
    @(posedge clk);
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fr = 1'b0;
    if (clr) begin
      pos = 0; msnap = 16'h0; mdp = 4'h0;
    end else if (en) begin
      if (pos == 0) begin
        msnap = data; mdp = dp_in; e_fr = 1'b1;
      end
      k = pos / DIV;
      c = pos % DIV;
      if (c >= BLANK && visible(k, msnap, mdp)) begin
        e_an[k] = 1'b0;
        e_seg   = ~HEX[msnap[4*k +: 4]];
        e_dp    = ~mdp[k];
      end
      pos = (pos + 1) % FRAME;
    end
    #1;
    chk("an", {12'h0, an}, {12'h0, e_an});
    chk("seg", {9'h0, seg}, {9'h0, e_seg});
    chk("dp", {15'h0, dp}, {15'h0, e_dp});
    chk("frame", {15'h0, frame}, {15'h0, e_fr});
  endtask

  task automatic do_reset(input int n);
    clr = 1'b1;
    repeat (n) tick();
    clr = 1'b0;
  endtask

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [6:0]  seg [4];
    logic [3:0]  dpn;
  } vec_t;

  vec_t tbl [4];

  initial begin
    tbl[0] = '{16'h1234, 4'b0000, '{7'h19, 7'h30, 7'h24, 7'h79}, 4'b1111};
    tbl[1] = '{16'hABCD, 4'b0000, '{7'h21, 7'h46, 7'h03, 7'h08}, 4'b1111};
    tbl[2] = '{16'hF0E9, 4'b1010, '{7'h10, 7'h06, 7'h40, 7'h0E}, 4'b0101};
    tbl[3] = '{16'h8765, 4'b0101, '{7'h12, 7'h02, 7'h78, 7'h00}, 4'b1010};

    // Reset state with en held high
    en = 1'b1;
    do_reset(3);
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_seg", {9'h0, seg}, 16'h007F);
    chk("rst_dp", {15'h0, dp}, 16'h0001);
    chk("rst_frame", {15'h0, frame}, 16'h0000);

    // Table vectors: one full frame per entry
    for (int v = 0; v < 4; v++) begin
      do_reset(2);
      data = tbl[v].data; dp_in = tbl[v].dp_in;
      for (int p = 0; p < FRAME; p++) begin
        tick();
        if (p == 0) chk("tbl_frame", {15'h0, frame}, 16'h0001);
        if (p % DIV >= BLANK) begin
          chk("tbl_an", {12'h0, an}, {12'h0, ~(4'b0001 << (p / DIV))});
          chk("tbl_seg", {9'h0, seg}, {9'h0, tbl[v].seg[p / DIV]});
          chk("tbl_dp", {15'h0, dp}, {15'h0, tbl[v].dpn[p / DIV]});
        end else begin
          chk("tbl_blank", {12'h0, an}, 16'h000F);
        end
      end
    end

    // Mid-frame data change is hidden until the next frame pulse
    do_reset(2);
    data = 16'h1234; dp_in = 4'h0;
    repeat (2 * DIV + 3) tick();
    data = 16'hABCD;
    repeat (2 * DIV - 3) tick();
    chk("hold_seg3", {9'h0, seg}, 16'h0079);
    repeat (BLANK + 1) tick();
    chk("new_seg0", {9'h0, seg}, 16'h0021);

    // Freeze at cnt=5 of slot 1, then resume
    do_reset(2);
    data = 16'h1234;
    repeat (DIV + 5) tick();
    en = 1'b0;
    tick();
    chk("frz_an", {12'h0, an}, 16'h000F);
    repeat (19) tick();
    chk("frz_frame", {15'h0, frame}, 16'h0000);
    en = 1'b1;
    tick(); chk("res_an0", {12'h0, an}, 16'h000D);
    tick(); tick(); chk("res_an2", {12'h0, an}, 16'h000D);
    tick(); chk("res_slot2", {12'h0, an}, 16'h000F);

    // Leading-zero cases
    do_reset(2);
    data = 16'h0070;
    repeat (FRAME) tick();
    data = 16'h0000; dp_in = 4'b0100;
    repeat (FRAME + 1) tick();
    dp_in = 4'h0;

    // clr pulse at cnt=6 of slot 3
    do_reset(2);
    data = 16'h5A5A;
    repeat (3 * DIV + 6) tick();
    clr = 1'b1;
    tick();
    chk("clr_an", {12'h0, an}, 16'h000F);
    clr = 1'b0;
    tick();
    chk("clr_frame", {15'h0, frame}, 16'h0001);

    // Randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 40) == 0) begin
        data = 16'($urandom);
        case ($urandom_range(0, 3))
          0: data = data & 16'h00FF;
          1: data = data & 16'h000F;
          2: data = 16'h0;
          default: ;
        endcase
      end
      if ($urandom_range(0, 60) == 0) dp_in = 4'($urandom);
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 300) == 0);
      tick();
    end
    clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
